// File: rtl/wb_trace_emitter_if.sv
// Writeback-trace capture and byte-stream bundle shared by the emitter and its driver/sink.
interface wb_trace_emitter_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic          TraceEnable;
    logic [31:0]   instrW;
    logic [4:0]    RegDestW;
    logic [31:0]   MuxResultW;
    logic          wbEnableW;
    logic [7:0]    TxData;
    logic          TxValid;
    logic          TxReady;
    logic          Overflow;
    logic [7:0]    DropCount;
    logic [LW-1:0] FifoLevel;

    modport master (
        output TraceEnable, instrW, RegDestW, MuxResultW, wbEnableW, TxReady,
        input  TxData, TxValid, Overflow, DropCount, FifoLevel
    );

    modport slave (
        input  TraceEnable, instrW, RegDestW, MuxResultW, wbEnableW, TxReady,
        output TxData, TxValid, Overflow, DropCount, FifoLevel
    );
endinterface

// File: rtl/wb_trace_emitter.sv
// Captures retiring writeback records into a FIFO and serialises them as a byte stream.
// Optional build macro: TRACE_CYCLE_STAMP_EN appends a 32-bit cycle stamp to every record.
module wb_trace_emitter #(
    parameter int unsigned DEPTH = 4
) (
    input logic               Clk,
    input logic               Rst_n,
    wb_trace_emitter_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH) + 1;
`ifdef TRACE_CYCLE_STAMP_EN
    localparam int unsigned NB  = 14;
    localparam logic [7:0]  HDR = 8'hA6;
`else
    localparam int unsigned NB  = 10;
    localparam logic [7:0]  HDR = 8'hA5;
`endif
    localparam int unsigned PB   = 8 * (NB - 1);
    localparam logic [3:0]  LAST = 4'(NB - 1);

    typedef struct packed {
        logic [31:0] instr;
        logic        wbEn;
        logic [4:0]  rd;
        logic [31:0] data;
`ifdef TRACE_CYCLE_STAMP_EN
        logic [31:0] stamp;
`endif
    } rec_t;

    typedef enum logic {IDLE, SEND} state_t;

    // Everything after the header byte, most significant byte sent first.
    function automatic logic [PB-1:0] payload(rec_t r);
`ifdef TRACE_CYCLE_STAMP_EN
        return {r.instr, r.wbEn, 2'b00, r.rd, r.data, r.stamp};
`else
        return {r.instr, r.wbEn, 2'b00, r.rd, r.data};
`endif
    endfunction

    rec_t           mem [DEPTH];
    logic [PW-1:0]  wrPtr, rdPtr;
    logic [LW-1:0]  level;
    state_t         state;
    logic [3:0]     idx;
    logic [PB-1:0]  shiftBuf;
    logic [7:0]     txData;
    logic           txValid;
    logic           overflow;
    logic [7:0]     dropCount;
    rec_t           capRec;
    logic           captureC, fullC, popC, pushC;
`ifdef TRACE_CYCLE_STAMP_EN
    logic [31:0]    cycleCnt;
`endif

    always_comb begin
        capRec       = '0;
        capRec.instr = bus.instrW;
        capRec.wbEn  = bus.wbEnableW;
        capRec.rd    = bus.RegDestW;
        capRec.data  = bus.MuxResultW;
`ifdef TRACE_CYCLE_STAMP_EN
        capRec.stamp = cycleCnt;
`endif
    end

    assign captureC = bus.TraceEnable && (bus.instrW != 32'h0);
    assign fullC    = (level == LW'(DEPTH));
    // A pop frees a slot on the same edge, so a full FIFO can still accept then.
    assign popC     = (level != '0) &&
                      ((state == IDLE) || (bus.TxReady && (idx == LAST)));
    assign pushC    = captureC && (!fullC || popC);

`ifdef TRACE_CYCLE_STAMP_EN
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) cycleCnt <= '0;
        else        cycleCnt <= cycleCnt + 32'd1;
    end
`endif

    always_ff @(posedge Clk) begin
        if (pushC) mem[wrPtr] <= capRec;
    end

    // FIFO pointers, level and drop accounting.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            dropCount <= 8'h00;
        end else begin
            if (pushC) wrPtr <= wrPtr + PW'(1);
            if (popC)  rdPtr <= rdPtr + PW'(1);
            case ({pushC, popC})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (captureC && !pushC) begin
                overflow <= 1'b1;
                if (dropCount != 8'hFF) dropCount <= dropCount + 8'd1;
            end
        end
    end

    // Serialiser: loads the header on pop, then shifts payload bytes out per handshake.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= IDLE;
            idx      <= 4'd0;
            shiftBuf <= '0;
            txData   <= 8'h00;
            txValid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (popC) begin
                        state    <= SEND;
                        idx      <= 4'd0;
                        shiftBuf <= payload(mem[rdPtr]);
                        txData   <= HDR;
                        txValid  <= 1'b1;
                    end
                end
                SEND: begin
                    if (bus.TxReady) begin
                        if (idx == LAST) begin
                            if (popC) begin
                                idx      <= 4'd0;
                                shiftBuf <= payload(mem[rdPtr]);
                                txData   <= HDR;
                            end else begin
                                state   <= IDLE;
                                txData  <= 8'h00;
                                txValid <= 1'b0;
                            end
                        end else begin
                            idx      <= idx + 4'd1;
                            txData   <= shiftBuf[PB-1 -: 8];
                            shiftBuf <= {shiftBuf[PB-9:0], 8'h00};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.TxData    = txData;
    assign bus.TxValid   = txValid;
    assign bus.Overflow  = overflow;
    assign bus.DropCount = dropCount;
    assign bus.FifoLevel = level;
endmodule
